// File: rtl/keypad_scanner_if.sv
// Keypad-side and user-side signals of the 4x4 keypad scanner.
// The master modport belongs to the scanner; the slave side is the keypad/user logic.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot active-low column drive, synchronised row
// sampling, per-scan lowest-key priority and a scan-rate press/release debouncer.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              rst,
  keypad_scanner_if.master bus
);

  localparam int unsigned     DivW    = $clog2(SCAN_DIV);
  localparam int unsigned     CntW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DbLimit = CntW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StIdle, StCand, StPressed} state_e;

  logic [3:0]      row_meta_q, row_sync_q;
  logic [DivW-1:0] dwell_q;
  logic [1:0]      col_idx_q;
  logic [3:0]      col_q;
  logic            acc_found_q;
  logic [3:0]      acc_code_q;

  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] rel_q, rel_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;

  logic            sample, scan_done;
  logic            hit, base_found, cur_found;
  logic [1:0]      row_idx;
  logic [3:0]      cur_code;

  assign sample    = (dwell_q == DivLast);
  assign scan_done = sample && (col_idx_q == 2'd3);

  // Lowest pressed row in the active column; earlier columns of this scan take priority.
  always_comb begin
    hit     = 1'b0;
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        hit     = 1'b1;
        row_idx = 2'(r);
      end
    end
    base_found = acc_found_q && (col_idx_q != 2'd0);
    cur_found  = base_found || hit;
    cur_code   = base_found ? acc_code_q : {col_idx_q, row_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      acc_found_q <= 1'b0;
      acc_code_q  <= 4'd0;
    end else begin
      row_meta_q <= bus.row;
      row_sync_q <= row_meta_q;
      if (sample) begin
        dwell_q     <= '0;
        col_idx_q   <= col_idx_q + 2'd1;
        col_q       <= {col_q[2:0], col_q[3]};
        acc_found_q <= cur_found;
        acc_code_q  <= cur_code;
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      rel_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Debouncer advances only once per full scan, on the column-3 sample.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (scan_done) begin
      unique case (state_q)
        StIdle: begin
          if (cur_found) begin
            cand_d = cur_code;
            cnt_d  = CntW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d     = StPressed;
              key_code_d  = cur_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_d       = '0;
            end else begin
              state_d = StCand;
            end
          end
        end
        StCand: begin
          if (!cur_found) begin
            state_d = StIdle;
          end else if (cur_code == cand_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DbLimit) begin
              state_d     = StPressed;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_d       = '0;
            end
          end else begin
            cand_d = cur_code;
            cnt_d  = CntW'(1);
          end
        end
        StPressed: begin
          if (cur_found && (cur_code == key_code_q)) begin
            rel_d = '0;
          end else begin
            rel_d = rel_q + 1'b1;
            if (rel_d == DbLimit) begin
              state_d    = StIdle;
              key_held_d = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.col       = col_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a per-scan reference
// model of the debounced key behaviour, with randomized key sequences.
module tb_keypad_scanner;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned DbScans = 3;
  localparam int unsigned ScanLen = 4 * ScanDiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = 16'h0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (per full scan)
  int          m_st;   // 0 idle, 1 candidate, 2 pressed
  int          m_cand;
  int          m_cnt;
  int          m_rel;
  logic [3:0]  m_code;
  logic        m_held;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV      (ScanDiv),
    .DEBOUNCE_SCANS(DbScans)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(kif)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] keypad_rows(input logic [15:0] p, input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int cc = 0; cc < 4; cc++) begin
      for (int rr = 0; rr < 4; rr++) begin
        if (p[cc*4+rr] && !c[cc]) r[rr] = 1'b0;
      end
    end
    return r;
  endfunction

  assign kif.row = keypad_rows(pressed, kif.col);

  function automatic logic [15:0] key_bit(input int k);
    logic [15:0] one;
    one = 16'h1;
    return one << k;
  endfunction

  task automatic model_reset();
    m_st   = 0;
    m_cand = 0;
    m_cnt  = 0;
    m_rel  = 0;
    m_code = 4'd0;
    m_held = 1'b0;
  endtask

  task automatic model_scan(input logic [15:0] p, output bit pulse);
    int  k;
    bit  accept;
    k      = -1;
    accept = 0;
    pulse  = 0;
    for (int i = 0; i < 16; i++) if (p[i] && k < 0) k = i;
    case (m_st)
      0: if (k >= 0) begin
        m_cand = k;
        m_cnt  = 1;
        if (m_cnt >= DbScans) accept = 1;
        else m_st = 1;
      end
      1: begin
        if (k < 0) m_st = 0;
        else if (k == m_cand) begin
          m_cnt++;
          if (m_cnt >= DbScans) accept = 1;
        end else begin
          m_cand = k;
          m_cnt  = 1;
        end
      end
      default: begin
        if (k == int'(m_code)) m_rel = 0;
        else begin
          m_rel++;
          if (m_rel >= DbScans) begin
            m_st   = 0;
            m_held = 1'b0;
          end
        end
      end
    endcase
    if (accept) begin
      m_st   = 2;
      m_code = 4'(m_cand);
      m_held = 1'b1;
      m_rel  = 0;
      pulse  = 1;
    end
  endtask

  // Runs one full scan starting 1 time unit into cycle 0 of the scan; ends likewise in the next.
  task automatic run_scan(input string tag);
    bit         exp_pulse;
    int         pulses;
    logic [3:0] prev_code, exp_col;
    logic       prev_held;
    prev_code = m_code;
    prev_held = m_held;
    model_scan(pressed, exp_pulse);
    pulses = 0;
    for (int i = 1; i <= int'(ScanLen); i++) begin
      @(posedge clk);
      #1;
      if (kif.key_valid === 1'b1) pulses++;
      exp_col = ~(4'(1) << ((i % ScanLen) / ScanDiv));
      n_vec++;
      if (kif.col !== exp_col) begin
        n_err++;
        $display("FAIL %s col c%0d: got %b want %b", tag, i, kif.col, exp_col);
      end
      if (i < int'(ScanLen)) begin
        n_vec++;
        if (kif.key_held !== prev_held || kif.key_code !== prev_code) begin
          n_err++;
          $display("FAIL %s midscan c%0d: held/code got %b/%0d want %b/%0d", tag, i,
                   kif.key_held, kif.key_code, prev_held, prev_code);
        end
      end
    end
    n_vec++;
    if (pulses !== int'(exp_pulse)) begin
      n_err++;
      $display("FAIL %s pulses: got %0d want %0d", tag, pulses, exp_pulse);
    end
    n_vec++;
    if (kif.key_code !== m_code) begin
      n_err++;
      $display("FAIL %s key_code: got %0d want %0d", tag, kif.key_code, m_code);
    end
    n_vec++;
    if (kif.key_held !== m_held) begin
      n_err++;
      $display("FAIL %s key_held: got %b want %b", tag, kif.key_held, m_held);
    end
  endtask

  task automatic do_reset(input int cycles, input string tag);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    n_vec++;
    if (kif.key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s valid_in_reset: got %b want 0", tag, kif.key_valid);
    end
    rst = 1'b0;
    model_reset();
    n_vec++;
    if (kif.col !== 4'b1110 || kif.key_held !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_reset: col/held got %b/%b want 1110/0", tag, kif.col, kif.key_held);
    end
  endtask

  task automatic scans(input int n, input string tag);
    for (int s = 0; s < n; s++) run_scan(tag);
  endtask

  task automatic test_reset();
    pressed = 16'h0;
    do_reset(3, "reset");
    n_vec++;
    if (kif.key_code !== 4'd0) begin
      n_err++;
      $display("FAIL reset key_code: got %0d want 0", kif.key_code);
    end
    scans(2, "reset");
  endtask

  task automatic test_hold_key();
    pressed = key_bit(9);
    scans(6, "hold");
  endtask

  task automatic test_bounce();
    pressed = 16'h0;
    scans(4, "bounce_rel");
    for (int s = 0; s < 20; s++) begin
      pressed = (s % 2 == 0) ? key_bit(9) : 16'h0;
      run_scan("bounce");
    end
    pressed = key_bit(9);
    scans(5, "bounce_hold");
  endtask

  task automatic test_simultaneous();
    pressed = 16'h0;
    scans(4, "simul_rel");
    pressed = key_bit(7) | key_bit(8);
    scans(5, "simul");
  endtask

  task automatic test_key_change();
    pressed = key_bit(9);
    scans(5, "change_9");
    pressed = key_bit(15);
    scans(8, "change_15");
  endtask

  task automatic test_reset_mid_press();
    pressed = 16'h0;
    scans(4, "midrst_rel");
    pressed = key_bit(9);
    scans(2, "midrst_pre");
    do_reset(1, "midrst");
    scans(4, "midrst_post");
  endtask

  task automatic test_random();
    int r;
    for (int seg = 0; seg < 30; seg++) begin
      r = int'($urandom_range(0, 4));
      if (r == 0) pressed = 16'h0;
      else pressed = key_bit(int'($urandom_range(0, 15)));
      if (r == 4) pressed = pressed | key_bit(int'($urandom_range(0, 15)));
      scans(int'($urandom_range(1, 5)), "random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hold_key();
    test_bounce();
    test_simultaneous();
    test_key_change();
    test_reset_mid_press();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
